// File: rtl/onehot_stream_decoder_if.sv
// onehot_stream_decoder_if
//   Bundles the encoded-grant handshake and the decoded output lines of
//   onehot_stream_decoder.
//   Upstream side (master): drives in_valid, code and idle_in, and observes
//   in_ready.
//   Decoder side (slave): drives in_ready, H, out_valid, out_code and idle_out.
//   Signals:
//     in_valid  - upstream item present
//     in_ready  - decoder can take an item this cycle
//     code      - encoded line index
//     idle_in   - item is an idle token (code ignored)
//     H         - registered one-hot decoded lines
//     out_valid - H carries a real grant
//     out_code  - registered copy of the code being driven
//     idle_out  - nothing driving and nothing pending
interface onehot_stream_decoder_if;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] code;
  logic       idle_in;
  logic [7:0] H;
  logic       out_valid;
  logic [2:0] out_code;
  logic       idle_out;

  modport master (
    output in_valid, code, idle_in,
    input  in_ready, H, out_valid, out_code, idle_out
  );

  modport slave (
    input  in_valid, code, idle_in,
    output in_ready, H, out_valid, out_code, idle_out
  );
endinterface

// File: rtl/onehot_stream_decoder.sv
// onehot_stream_decoder
//   Receive-side partner of the 8-input priority encoder. Each accepted
//   grant (3-bit code or idle token) is turned back into a one-hot line that
//   is held on H for HOLD_CYCLES cycles. A one-entry pending register lets the
//   encoder push the next item while the current one is still being held.
//   Parameters:
//     HOLD_CYCLES - cycles each item occupies the output (1..16)
//   Ports:
//     clk         - rising-edge clock
//     rst_n       - synchronous reset, active low
//     bus         - slave side of onehot_stream_decoder_if
//     clr_mask    - clears the sticky mask (DECODER_STICKY_MASK_EN only)
//     sticky_mask - OR of every line driven since the last clear
//                   (DECODER_STICKY_MASK_EN only)
//   Optional feature macro: DECODER_STICKY_MASK_EN
module onehot_stream_decoder #(
  parameter int HOLD_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  onehot_stream_decoder_if.slave  bus
`ifdef DECODER_STICKY_MASK_EN
  ,
  input  logic                    clr_mask,
  output logic [7:0]              sticky_mask
`endif
);

  // 4-bit compare value; HOLD_CYCLES=16 gives 15 so the counter wraps to 0
  // exactly when the slot frees.
  localparam logic [3:0] LAST_CNT = 4'(HOLD_CYCLES - 1);

  typedef enum logic {IDLE, DRIVE} state_t;

  state_t     state_q, state_d;
  logic [2:0] cur_code_q, cur_code_d;
  logic       cur_idle_q, cur_idle_d;
  logic [3:0] cnt_q, cnt_d;
  logic       pend_valid_q, pend_valid_d;
  logic [2:0] pend_code_q, pend_code_d;
  logic       pend_idle_q, pend_idle_d;
  logic [7:0] h_q, h_d;
  logic       out_valid_q, out_valid_d;
  logic [2:0] out_code_q, out_code_d;

  logic in_ready;
  logic accept;
  logic slot_free;

  assign in_ready  = rst_n & ~pend_valid_q;
  assign accept    = bus.in_valid & in_ready;
  assign slot_free = (state_q == IDLE) || (cnt_q == LAST_CNT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cur_code_q   <= '0;
      cur_idle_q   <= 1'b0;
      cnt_q        <= '0;
      pend_valid_q <= 1'b0;
      pend_code_q  <= '0;
      pend_idle_q  <= 1'b0;
      h_q          <= '0;
      out_valid_q  <= 1'b0;
      out_code_q   <= '0;
    end else begin
      state_q      <= state_d;
      cur_code_q   <= cur_code_d;
      cur_idle_q   <= cur_idle_d;
      cnt_q        <= cnt_d;
      pend_valid_q <= pend_valid_d;
      pend_code_q  <= pend_code_d;
      pend_idle_q  <= pend_idle_d;
      h_q          <= h_d;
      out_valid_q  <= out_valid_d;
      out_code_q   <= out_code_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cur_code_d   = cur_code_q;
    cur_idle_d   = cur_idle_q;
    cnt_d        = cnt_q;
    pend_valid_d = pend_valid_q;
    pend_code_d  = pend_code_q;
    pend_idle_d  = pend_idle_q;

    if (slot_free) begin
      // Pending always wins; an accept cannot coincide with a valid pending
      // entry because in_ready is low then.
      cnt_d = '0;
      if (pend_valid_q) begin
        state_d      = DRIVE;
        cur_code_d   = pend_code_q;
        cur_idle_d   = pend_idle_q;
        pend_valid_d = 1'b0;
      end else if (accept) begin
        state_d    = DRIVE;
        cur_code_d = bus.code;
        cur_idle_d = bus.idle_in;
      end else begin
        state_d = IDLE;
      end
    end else begin
      cnt_d = cnt_q + 4'd1;
      if (accept) begin
        pend_valid_d = 1'b1;
        pend_code_d  = bus.code;
        pend_idle_d  = bus.idle_in;
      end
    end
  end

  // Outputs are registered from the next slot contents so H changes on the
  // same edge that loads an item.
  always_comb begin
    h_d         = '0;
    out_valid_d = 1'b0;
    out_code_d  = '0;
    if (state_d == DRIVE && !cur_idle_d) begin
      h_d         = 8'd1 << cur_code_d;
      out_valid_d = 1'b1;
      out_code_d  = cur_code_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.H         = h_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_code  = out_code_q;
  assign bus.idle_out  = (state_q == IDLE) && !pend_valid_q;

`ifdef DECODER_STICKY_MASK_EN
  logic [7:0] sticky_q, sticky_d;

  // A line rising on the same edge as a clear survives the clear.
  always_comb begin
    sticky_d = (clr_mask ? 8'h00 : sticky_q) | h_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) sticky_q <= '0;
    else        sticky_q <= sticky_d;
  end

  assign sticky_mask = sticky_q;
`endif

endmodule

// File: tb/tb_onehot_stream_decoder.sv
// tb_onehot_stream_decoder
//   Drives four decoder instances (HOLD_CYCLES = 1, 2, 3, 16) from shared
//   inputs; each test resets everything and checks only the instance it
//   targets, selected by 'sel'.
module tb_onehot_stream_decoder;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [2:0] code;
  logic       idle_in;
  logic       clr_mask;

  int checks = 0;
  int errors = 0;
  int sel    = 1;

  onehot_stream_decoder_if if1 ();
  onehot_stream_decoder_if if2 ();
  onehot_stream_decoder_if if3 ();
  onehot_stream_decoder_if if16 ();

  assign if1.in_valid  = in_valid;
  assign if1.code      = code;
  assign if1.idle_in   = idle_in;
  assign if2.in_valid  = in_valid;
  assign if2.code      = code;
  assign if2.idle_in   = idle_in;
  assign if3.in_valid  = in_valid;
  assign if3.code      = code;
  assign if3.idle_in   = idle_in;
  assign if16.in_valid = in_valid;
  assign if16.code     = code;
  assign if16.idle_in  = idle_in;

`ifdef DECODER_STICKY_MASK_EN
  logic [7:0] sticky1, sticky2, sticky3, sticky16;
  onehot_stream_decoder #(.HOLD_CYCLES(1))  u1  (.clk(clk), .rst_n(rst_n), .bus(if1),  .clr_mask(clr_mask), .sticky_mask(sticky1));
  onehot_stream_decoder #(.HOLD_CYCLES(2))  u2  (.clk(clk), .rst_n(rst_n), .bus(if2),  .clr_mask(clr_mask), .sticky_mask(sticky2));
  onehot_stream_decoder #(.HOLD_CYCLES(3))  u3  (.clk(clk), .rst_n(rst_n), .bus(if3),  .clr_mask(clr_mask), .sticky_mask(sticky3));
  onehot_stream_decoder #(.HOLD_CYCLES(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(if16), .clr_mask(clr_mask), .sticky_mask(sticky16));
`else
  onehot_stream_decoder #(.HOLD_CYCLES(1))  u1  (.clk(clk), .rst_n(rst_n), .bus(if1));
  onehot_stream_decoder #(.HOLD_CYCLES(2))  u2  (.clk(clk), .rst_n(rst_n), .bus(if2));
  onehot_stream_decoder #(.HOLD_CYCLES(3))  u3  (.clk(clk), .rst_n(rst_n), .bus(if3));
  onehot_stream_decoder #(.HOLD_CYCLES(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(if16));
`endif

  // Outputs of the instance under test
  logic [7:0] cur_h;
  logic       cur_ready, cur_ov, cur_io;
  logic [2:0] cur_oc;

  always_comb begin
    cur_h = if1.H; cur_ready = if1.in_ready; cur_ov = if1.out_valid;
    cur_io = if1.idle_out; cur_oc = if1.out_code;
    case (sel)
      2: begin
        cur_h = if2.H; cur_ready = if2.in_ready; cur_ov = if2.out_valid;
        cur_io = if2.idle_out; cur_oc = if2.out_code;
      end
      3: begin
        cur_h = if3.H; cur_ready = if3.in_ready; cur_ov = if3.out_valid;
        cur_io = if3.idle_out; cur_oc = if3.out_code;
      end
      16: begin
        cur_h = if16.H; cur_ready = if16.in_ready; cur_ov = if16.out_valid;
        cur_io = if16.idle_out; cur_oc = if16.out_code;
      end
      default: ;
    endcase
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog");
  end

  // Vector table record for the HOLD_CYCLES=1 instance
  typedef struct {
    logic       v;
    logic [2:0] c;
    logic       idl;
    logic [7:0] h;
    logic       ov;
    logic [2:0] oc;
    logic       rdy;
    logic       io;
  } vec_t;

  vec_t tbl[12];

  // Stream-runner item list and per-cycle expectations
  logic [2:0] s_code[8];
  logic       s_idle[8];
  int         s_n;
  logic [7:0] e_h[40];
  logic       e_rdy[40];
  logic       e_ov[40];
  logic       e_io[40];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] c, input logic idl);
    @(negedge clk);
    in_valid = v;
    code     = c;
    idle_in  = idl;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    code     = 3'd0;
    idle_in  = 1'b0;
    clr_mask = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Offers s_code/s_idle in order, advancing only on a real handshake, and
  // compares outputs after every edge against the e_* arrays.
  task automatic runStream(input string tag, input int ncyc);
    int   idx;
    logic rdy_pre;
    idx = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      in_valid = (idx < s_n);
      code     = (idx < s_n) ? s_code[idx] : 3'd0;
      idle_in  = (idx < s_n) ? s_idle[idx] : 1'b0;
      #1;
      rdy_pre = cur_ready;
      @(posedge clk);
      if (in_valid && rdy_pre) idx++;
      #1;
      checkOutput($sformatf("%s c%0d H", tag, c), cur_h, e_h[c]);
      checkOutput($sformatf("%s c%0d ready", tag, c), cur_ready, e_rdy[c]);
      checkOutput($sformatf("%s c%0d out_valid", tag, c), cur_ov, e_ov[c]);
      checkOutput($sformatf("%s c%0d idle_out", tag, c), cur_io, e_io[c]);
    end
    checkOutput({tag, " items accepted"}, idx, s_n);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    code     = 3'd0;
    idle_in  = 1'b0;
    clr_mask = 1'b0;

    // Table for HOLD_CYCLES=1: single item, walk 0..7, idle token
    tbl[0]  = '{1'b1, 3'd5, 1'b0, 8'h20, 1'b1, 3'd5, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++)
      tbl[2+i] = '{1'b1, 3'(i), 1'b0, 8'(1 << i), 1'b1, 3'(i), 1'b1, 1'b0};
    tbl[10] = '{1'b1, 3'd3, 1'b1, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b1};

    // Reset state
    sel = 1;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("reset H", cur_h, 8'h00);
    checkOutput("reset out_valid", cur_ov, 1'b0);
    checkOutput("reset out_code", cur_oc, 3'd0);
    checkOutput("reset idle_out", cur_io, 1'b1);
    checkOutput("reset in_ready", cur_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("post-reset in_ready", cur_ready, 1'b1);

    // Table-driven HOLD_CYCLES=1
    for (int i = 0; i < 12; i++) begin
      applyStimulus(tbl[i].v, tbl[i].c, tbl[i].idl);
      checkOutput($sformatf("tbl%0d H", i), cur_h, tbl[i].h);
      checkOutput($sformatf("tbl%0d out_valid", i), cur_ov, tbl[i].ov);
      checkOutput($sformatf("tbl%0d out_code", i), cur_oc, tbl[i].oc);
      checkOutput($sformatf("tbl%0d in_ready", i), cur_ready, tbl[i].rdy);
      checkOutput($sformatf("tbl%0d idle_out", i), cur_io, tbl[i].io);
    end

    // HOLD_CYCLES=3: items 2,6,1 offered continuously
    doReset();
    sel = 3;
    s_n = 3;
    s_code[0] = 3'd2; s_idle[0] = 1'b0;
    s_code[1] = 3'd6; s_idle[1] = 1'b0;
    s_code[2] = 3'd1; s_idle[2] = 1'b0;
    for (int c = 0; c < 12; c++) begin
      e_h[c]   = (c < 3) ? 8'h04 : (c < 6) ? 8'h40 : (c < 9) ? 8'h02 : 8'h00;
      e_rdy[c] = !(c == 1 || c == 2 || c == 4 || c == 5);
      e_ov[c]  = (c < 9);
      e_io[c]  = (c >= 9);
    end
    runStream("hold3", 12);

    // HOLD_CYCLES=2: code 3, idle token, code 4
    doReset();
    sel = 2;
    s_n = 3;
    s_code[0] = 3'd3; s_idle[0] = 1'b0;
    s_code[1] = 3'd5; s_idle[1] = 1'b1;
    s_code[2] = 3'd4; s_idle[2] = 1'b0;
    for (int c = 0; c < 8; c++) begin
      e_h[c]   = (c < 2) ? 8'h08 : (c < 4) ? 8'h00 : (c < 6) ? 8'h10 : 8'h00;
      e_rdy[c] = !(c == 1 || c == 3);
      e_ov[c]  = (c < 2) || (c == 4) || (c == 5);
      e_io[c]  = (c >= 6);
    end
    runStream("idletok", 8);

    // HOLD_CYCLES=16: counter wraps 15 -> 0 as the slot frees
    doReset();
    sel = 16;
    s_n = 2;
    s_code[0] = 3'd5; s_idle[0] = 1'b0;
    s_code[1] = 3'd6; s_idle[1] = 1'b0;
    for (int c = 0; c < 34; c++) begin
      e_h[c]   = (c < 16) ? 8'h20 : (c < 32) ? 8'h40 : 8'h00;
      e_rdy[c] = (c == 0) || (c >= 16);
      e_ov[c]  = (c < 32);
      e_io[c]  = (c >= 32);
    end
    runStream("hold16", 34);

    // Reset mid-hold with an item pending
    doReset();
    sel = 3;
    applyStimulus(1'b1, 3'd2, 1'b0);
    checkOutput("midrst first H", cur_h, 8'h04);
    applyStimulus(1'b1, 3'd6, 1'b0);
    checkOutput("midrst pending ready", cur_ready, 1'b0);
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midrst H", cur_h, 8'h00);
    checkOutput("midrst idle_out", cur_io, 1'b1);
    checkOutput("midrst in_ready", cur_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1'b0, 3'd0, 1'b0);
      checkOutput($sformatf("midrst after c%0d H", c), cur_h, 8'h00);
      checkOutput($sformatf("midrst after c%0d idle_out", c), cur_io, 1'b1);
    end

`ifdef DECODER_STICKY_MASK_EN
    // Sticky mask: set on the same edge as a clear wins
    doReset();
    sel = 1;
    applyStimulus(1'b1, 3'd1, 1'b0);
    checkOutput("sticky after 1", sticky1, 8'h02);
    applyStimulus(1'b1, 3'd4, 1'b0);
    checkOutput("sticky after 4", sticky1, 8'h12);
    clr_mask = 1'b1;
    applyStimulus(1'b1, 3'd7, 1'b0);
    checkOutput("sticky clr+7", sticky1, 8'h80);
    clr_mask = 1'b0;
    applyStimulus(1'b0, 3'd0, 1'b0);
    checkOutput("sticky holds", sticky1, 8'h80);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/onehot_stream_decoder.md
# onehot_stream_decoder

Sequential 3-to-8 decoder: the receive-side counterpart of the 8-input priority encoder. It accepts a stream of encoded grants (3-bit code plus idle flag) over a valid/ready handshake. Each grant is turned back into a one-hot line held for a programmable number of cycles. A one-entry holding register lets the upstream encoder run back-to-back without dropping codes. It sits downstream of the encoder, driving per-line enables in the consuming datapath.

## Interface
- HOLD_CYCLES, default 1: cycles each decoded item occupies the output; legal range 1..16.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active low.
- in_valid  input  1  upstream item present.
- in_ready  output  1  decoder can accept an item this cycle.
- code  input  3  encoded line index B2..B0.
- idle_in  input  1  item is an "idle" token; code ignored.
- H  output  8  one-hot decoded lines, registered.
- out_valid  output  1  H carries a real (non-idle) grant.
- out_code  output  3  registered copy of the code being driven.
- idle_out  output  1  nothing driving and nothing pending.

## Operation
- Handshake: an item transfers on a rising edge where in_valid=1 and in_ready=1. Upstream holds code/idle_in stable while in_valid=1 and in_ready=0.
- Storage: a drive slot (cur_code, cur_idle, hold counter) and a one-entry pending register.
- in_ready = rst_n & ~pend_valid (combinational).
- FSM states:
  - IDLE: H=0, out_valid=0.
  - DRIVE: the slot is active.
- Slot frees on an edge when the state is IDLE, or the state is DRIVE with counter = HOLD_CYCLES-1.
- Load priority on a freeing edge:
  - pending entry, if valid; pend_valid clears;
  - else an item accepted on this edge (bypass);
  - else go to IDLE.
- An item accepted on an edge where the slot does not free goes to pending.
- In DRIVE, a real item gives H = 1<<cur_code, out_valid=1, out_code=cur_code.
- In DRIVE, an idle item gives H=0, out_valid=0, out_code=0. It still occupies HOLD_CYCLES cycles, which preserves encoder timing.
- The counter starts at 0 on load and increments each DRIVE cycle.
- idle_out = (state==IDLE) & ~pend_valid.
- Exactly one H bit is set, or none. Multiple bits is a bug.

## Timing
- Reset values (rst_n low at an edge):
  - H=0, out_valid=0, out_code=0, idle_out=1;
  - state IDLE, counter 0, pend_valid=0;
  - in_ready=0 while rst_n low, 1 the first cycle after.
- Latency: item accepted at edge k with a free slot gives H valid from edge k through edge k+HOLD_CYCLES.
- Throughput:
  - HOLD_CYCLES=1: one item per cycle with in_ready held high.
  - HOLD_CYCLES=N: one item per N cycles. in_ready drops after a second item enters pending and rises the cycle after pending moves into the slot.
- Simultaneous free and accept with pending valid: impossible, since in_ready=0.
- Reset mid-DRIVE: H drops to 0 on the reset edge and the pending item is discarded. No partial hold resumes.
- Counter compares against HOLD_CYCLES-1 using a 4-bit width. HOLD_CYCLES=16 wraps the counter 15→0 exactly at slot free.

## Configuration
- DECODER_STICKY_MASK_EN defined adds:
  - input clr_mask (1 bit);
  - output sticky_mask (8 bits, reset 0).
- Each edge: sticky_mask ← (clr_mask ? 0 : sticky_mask) | H_next.
  - A set on the same edge as a clear wins.
  - Bits update in the same cycle H rises.
- Not defined: both ports are absent and no mask logic is built.

## Test plan
- Reset then single item (HOLD_CYCLES=1, code=5 at edge k): H=8'b0010_0000, out_valid=1, out_code=5 for one cycle; H=0 and idle_out=1 after.
- Back-to-back codes 0..7 (HOLD_CYCLES=1, in_valid held): in_ready stays 1, and H walks 01,02,04…80 on consecutive cycles.
- HOLD_CYCLES=3, three items 2,6,1 offered continuously:
  - H=04 for 3 cycles, then 40 for 3, then 02 for 3;
  - in_ready=0 while item 3 waits;
  - no item lost.
- Idle token between codes 3 and 4 (HOLD_CYCLES=2): H=08 ×2, then 00 ×2 with out_valid=0 and idle_out=0, then 10 ×2.
- rst_n low mid-hold with an item pending: next cycle H=0, idle_out=1, in_ready=0. After release, the pending item never appears.
- DECODER_STICKY_MASK_EN: codes 1,4, then clr_mask asserted with code 7 on the same edge; sticky_mask goes 02→12→80.
